prga: RTL and testbench
=======================

// Module: prga
// PURPOSE
//  RC4 keystream/decrypt stage: runs the PRGA loop over the already-keyed S
//  memory (left by ksa) and XORs each keystream byte with the ciphertext.
//  Reads ct memory (length-prefixed message, same ct_addr/ct_rddata bus crack
//  uses) and writes pt memory, which crack then scans for a printable message.
//  Sits after ksa inside arc4; launched and polled through the en/rdy handshake.
// PARAMETERS
//  LEN_ADDR  8'd0  ct/pt address that holds the message length byte
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  en         in   1  start request, sampled only while rdy=1
//  rdy        out  1  1 = idle and able to accept en
//  s_addr     out  8  S memory address
//  s_rddata   in   8  S memory read data (1-cycle sync read)
//  s_wrdata   out  8  S memory write data
//  s_wren     out  1  S memory write enable
//  ct_addr    out  8  ciphertext memory address
//  ct_rddata  in   8  ciphertext read data (1-cycle sync read)
//  pt_addr    out  8  plaintext memory address
//  pt_wrdata  out  8  plaintext write data
//  pt_wren    out  1  plaintext write enable
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, rdy=1, i=j=k=len=0, all addr/wrdata=0,
//    s_wren=pt_wren=0. Reset mid-run abandons the message; no further writes.
//  - Memories: address driven in cycle N, rddata captured at end of cycle N+1.
//  - Handshake: en&&rdy at edge E0 accepts; rdy=0 from E0 until run ends.
//    en while rdy=0 ignored. en held high at completion starts a new run.
//  - All index arithmetic mod 256 (8-bit wrap); j=j+si, pad addr=si+sj wrap.
//  - States, one cycle each:
//    IDLE:   rdy=1; en -> RD_LEN, clear i,j, k=1.
//    RD_LEN: ct_addr=LEN_ADDR -> WR_LEN.
//    WR_LEN: len=ct_rddata; pt[LEN_ADDR]=len (pt_wren=1); len==0 -> IDLE
//            else -> RD_SI.
//    RD_SI:  i=i+1; s_addr=i+1 -> RD_SJ.
//    RD_SJ:  si=s_rddata; j=j+si; s_addr=j+si -> WR_SI.
//    WR_SI:  sj=s_rddata; s[i]=sj (s_wren=1) -> WR_SJ.
//    WR_SJ:  s[j]=si (s_wren=1) -> RD_PAD.
//    RD_PAD: s_addr=si+sj; ct_addr=k -> WR_PT.
//    WR_PT:  pt[k]=s_rddata^ct_rddata (pt_wren=1); k==len -> IDLE
//            else k=k+1 -> RD_SI.
//  - Latency: rdy returns high after edge E0+2+6*len (len=0: E0+2).
//  - i==j case (swap of same cell) writes the same value twice; legal.
//  - len=255: k reaches 255, no wrap into LEN_ADDR; pt[1..255] all written.
//  - Write enables high for exactly one cycle per write; never both s_wren
//    and an S read in the same cycle; never a pt write outside WR_LEN/WR_PT.
//  - S memory left in post-PRGA state; caller re-runs init/ksa per key.
// TESTING
//  1 S=identity, ct={01,41} -> pt={01,43}; s unchanged; rdy high at E0+8.
//  2 S=identity, ct={02,41,00} -> pt={02,43,05}; s[2]=03,s[3]=02; rdy at E0+14.
//  3 ct[0]=00 -> pt[0]=00 only, no s_wren ever, rdy high at E0+2.
//  4 Known RC4 vector (key 0x000018 after init+ksa, lab ciphertext) -> pt
//    matches software model byte for byte, len byte copied.
//  5 en pulsed again at E0+3 -> ignored, single run; en held high -> back-to-
//    back run accepted in the cycle rdy=1.
//  6 rst_n low at E0+5 -> rdy=1, wrens=0 immediately (async); later en starts
//    a clean run with i=j=0.

Source files
------------

// File: rtl/prga.sv
`default_nettype none
// ============================================================================
//  Module   : prga
//  Brief    : RC4 keystream / decrypt stage. Runs the PRGA loop over an
//             already-keyed S memory and XORs each keystream byte with the
//             ciphertext. The message length is copied to the plaintext
//             memory first, followed by one plaintext byte per keystream byte.
//  Revision : 1.0  initial release
// ============================================================================
module prga #(
  parameter logic [7:0] LEN_ADDR = 8'd0  // ct/pt address holding the length byte
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  // One state per memory access. Both memories have a one-cycle synchronous
  // read, so every read state is followed by a state that consumes the data.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RD_LEN = 4'd1,
    ST_WR_LEN = 4'd2,
    ST_RD_SI  = 4'd3,
    ST_RD_SJ  = 4'd4,
    ST_WR_SI  = 4'd5,
    ST_WR_SJ  = 4'd6,
    ST_RD_PAD = 4'd7,
    ST_WR_PT  = 4'd8
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  // PRGA indices, message position/length and the two swapped S values.
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [7:0] r_k;
  logic [7:0] r_len;
  logic [7:0] r_si;
  logic [7:0] r_sj;

  // Index arithmetic, all 8-bit so it wraps mod 256 for free.
  logic [7:0] w_i_inc;
  logic [7:0] w_j_sum;
  logic [7:0] w_pad_addr;
  logic       w_last;

  assign w_i_inc    = r_i + 8'd1;
  assign w_j_sum    = r_j + s_rddata;   // s_rddata holds S[i] during RD_SJ
  assign w_pad_addr = r_si + r_sj;
  assign w_last     = (r_k == r_len);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and memory-port decode; outputs are purely a function of the
  // current state so a reset drops every enable in the same instant.
  always_comb begin
    w_state_nxt = r_state;
    rdy         = 1'b0;
    s_addr      = 8'd0;
    s_wrdata    = 8'd0;
    s_wren      = 1'b0;
    ct_addr     = 8'd0;
    pt_addr     = 8'd0;
    pt_wrdata   = 8'd0;
    pt_wren     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          w_state_nxt = ST_RD_LEN;
        end
      end

      ST_RD_LEN: begin
        ct_addr     = LEN_ADDR;
        w_state_nxt = ST_WR_LEN;
      end

      ST_WR_LEN: begin
        // Length byte is passed straight through to the plaintext memory.
        pt_addr   = LEN_ADDR;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        if (ct_rddata == 8'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RD_SI;
        end
      end

      ST_RD_SI: begin
        s_addr      = w_i_inc;
        w_state_nxt = ST_RD_SJ;
      end

      ST_RD_SJ: begin
        s_addr      = w_j_sum;
        w_state_nxt = ST_WR_SI;
      end

      ST_WR_SI: begin
        // S[j] is on the read bus this cycle; write it into S[i] directly.
        s_addr      = r_i;
        s_wrdata    = s_rddata;
        s_wren      = 1'b1;
        w_state_nxt = ST_WR_SJ;
      end

      ST_WR_SJ: begin
        s_addr      = r_j;
        s_wrdata    = r_si;
        s_wren      = 1'b1;
        w_state_nxt = ST_RD_PAD;
      end

      ST_RD_PAD: begin
        s_addr      = w_pad_addr;
        ct_addr     = r_k;
        w_state_nxt = ST_WR_PT;
      end

      ST_WR_PT: begin
        pt_addr   = r_k;
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RD_SI;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath registers, each updated only in the state that produces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i   <= 8'd0;
      r_j   <= 8'd0;
      r_k   <= 8'd0;
      r_len <= 8'd0;
      r_si  <= 8'd0;
      r_sj  <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_i <= 8'd0;
            r_j <= 8'd0;
            r_k <= 8'd1;
          end
        end
        ST_WR_LEN: begin
          r_len <= ct_rddata;
        end
        ST_RD_SI: begin
          r_i <= w_i_inc;
        end
        ST_RD_SJ: begin
          r_si <= s_rddata;
          r_j  <= w_j_sum;
        end
        ST_WR_SI: begin
          r_sj <= s_rddata;
        end
        ST_WR_PT: begin
          // k stops at len, so a 255-byte message never wraps onto LEN_ADDR.
          if (!w_last) begin
            r_k <= r_k + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prga.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prga
//  Brief    : Directed self-checking bench for prga with S/ct/pt memory
//             models (one-cycle synchronous read).
//  Revision : 1.0  initial release
// ============================================================================
module tb_prga;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  prga #(.LEN_ADDR(8'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models
  logic [7:0] s_init [256];
  logic [7:0] s_mem  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic       ld_req;
  int         n_swren;
  int         n_ptwr;

  // Synchronous-read memories; ld_req reloads S, clears pt, zeroes counters.
  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (ld_req) begin
      for (int a = 0; a < 256; a++) begin
        s_mem[a]  <= s_init[a];
        pt_mem[a] <= 8'hAA;
      end
      n_swren <= 0;
      n_ptwr  <= 0;
    end else begin
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        n_swren       <= n_swren + 1;
      end
      if (pt_wren) begin
        pt_mem[pt_addr] <= pt_wrdata;
        n_ptwr          <= n_ptwr + 1;
      end
    end
  end

  int n_chk;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_mems();
    @(posedge clk); #1 ld_req = 1'b1;
    @(posedge clk); #1 ld_req = 1'b0;
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
  endtask

  task automatic clear_ct();
    for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
  endtask

  // Pulses en for one edge (E0); returns 1ns after E0.
  task automatic start_run();
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
  endtask

  // Counts edges until rdy is seen high, starting from n0.
  task automatic wait_rdy(input int n0, output int n);
    n = n0;
    while (!rdy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Software RC4 model for the known vector
  logic [7:0] m_s   [256];
  logic [7:0] key   [3];
  logic [7:0] exp_pt[256];
  logic [7:0] t;
  logic [7:0] mi, mj;
  int         cyc;
  int         diffs;
  int         snap;
  logic [7:0] ct_vec [12];

  initial begin
    n_chk  = 0;
    n_bad  = 0;
    en     = 1'b0;
    ld_req = 1'b0;
    rst_n  = 1'b0;
    set_identity();
    clear_ct();

    // Reset state
    #12;
    chk("rst_rdy", rdy, 1);
    chk("rst_s_wren", s_wren, 0);
    chk("rst_pt_wren", pt_wren, 0);
    chk("rst_addrs", {s_addr, ct_addr, pt_addr}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: identity S, one byte
    set_identity(); clear_ct();
    ct_mem[0] = 8'h01; ct_mem[1] = 8'h41;
    load_mems();
    start_run();
    wait_rdy(0, cyc);
    chk("t1_latency", cyc, 8);
    chk("t1_pt0", pt_mem[0], 8'h01);
    chk("t1_pt1", pt_mem[1], 8'h43);
    diffs = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== 8'(a)) diffs++;
    chk("t1_s_unchanged", diffs, 0);
    chk("t1_swren_cnt", n_swren, 2);
    chk("t1_ptwr_cnt", n_ptwr, 2);

    // 2: identity S, two bytes
    set_identity(); clear_ct();
    ct_mem[0] = 8'h02; ct_mem[1] = 8'h41; ct_mem[2] = 8'h00;
    load_mems();
    start_run();
    wait_rdy(0, cyc);
    chk("t2_latency", cyc, 14);
    chk("t2_pt", {pt_mem[0], pt_mem[1], pt_mem[2]}, {8'h02, 8'h43, 8'h05});
    chk("t2_s23", {s_mem[2], s_mem[3]}, {8'h03, 8'h02});
    chk("t2_s1", s_mem[1], 8'h01);
    chk("t2_ptwr_cnt", n_ptwr, 3);

    // 3: empty message
    set_identity(); clear_ct();
    ct_mem[1] = 8'h55;
    load_mems();
    start_run();
    wait_rdy(0, cyc);
    chk("t3_latency", cyc, 2);
    chk("t3_pt0", pt_mem[0], 8'h00);
    chk("t3_pt1_untouched", pt_mem[1], 8'hAA);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_swren_cnt", n_swren, 0);
    chk("t3_ptwr_cnt", n_ptwr, 1);

    // 4: known RC4 vector, key 00 00 18
    key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'h18;
    for (int a = 0; a < 256; a++) m_s[a] = 8'(a);
    mj = 8'd0;
    for (int a = 0; a < 256; a++) begin
      mj = mj + m_s[a] + key[a % 3];
      t = m_s[a]; m_s[a] = m_s[mj]; m_s[mj] = t;
    end
    for (int a = 0; a < 256; a++) s_init[a] = m_s[a];
    ct_vec = '{8'h56, 8'hA3, 8'h0F, 8'hC4, 8'h9B, 8'h21, 8'hE8, 8'h73, 8'h5D, 8'h3A, 8'hBE, 8'h10};
    clear_ct();
    ct_mem[0] = 8'd12;
    for (int a = 0; a < 12; a++) ct_mem[a + 1] = ct_vec[a];
    mi = 8'd0; mj = 8'd0;
    exp_pt[0] = 8'd12;
    for (int a = 1; a <= 12; a++) begin
      mi = mi + 8'd1;
      mj = mj + m_s[mi];
      t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
      exp_pt[a] = m_s[8'(m_s[mi] + m_s[mj])] ^ ct_vec[a - 1];
    end
    load_mems();
    start_run();
    wait_rdy(0, cyc);
    chk("t4_latency", cyc, 2 + 6 * 12);
    diffs = 0;
    for (int a = 0; a <= 12; a++) if (pt_mem[a] !== exp_pt[a]) diffs++;
    chk("t4_pt_bytes", diffs, 0);
    chk("t4_len_copy", pt_mem[0], 8'd12);
    diffs = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) diffs++;
    chk("t4_s_final", diffs, 0);

    // 5a: second en pulse during a run is ignored
    set_identity(); clear_ct();
    ct_mem[0] = 8'h01; ct_mem[1] = 8'h41;
    load_mems();
    start_run();
    @(posedge clk); #1;
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    wait_rdy(3, cyc);
    chk("t5_pulse_latency", cyc, 8);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_pulse_rdy", rdy, 1);
    chk("t5_pulse_ptwr", n_ptwr, 2);

    // 5b: en held high gives a back-to-back run
    load_mems();
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1;
    wait_rdy(0, cyc);
    chk("t5_b2b_first", cyc, 8);
    @(posedge clk); #1;
    chk("t5_b2b_accept", rdy, 0);
    en = 1'b0;
    wait_rdy(0, cyc);
    chk("t5_b2b_second", cyc, 8);
    chk("t5_b2b_ptwr", n_ptwr, 4);
    chk("t5_b2b_pt1", pt_mem[1], 8'h43);

    // 6: asynchronous reset mid-run
    set_identity(); clear_ct();
    ct_mem[0] = 8'h02; ct_mem[1] = 8'h41; ct_mem[2] = 8'h00;
    load_mems();
    start_run();
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rdy", rdy, 1);
    chk("t6_rst_wrens", {s_wren, pt_wren}, 0);
    snap = n_swren + n_ptwr;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_writes", n_swren + n_ptwr, snap);
    rst_n = 1'b1;
    load_mems();
    start_run();
    wait_rdy(0, cyc);
    chk("t6_clean_latency", cyc, 14);
    chk("t6_clean_pt", {pt_mem[0], pt_mem[1], pt_mem[2]}, {8'h02, 8'h43, 8'h05});
    chk("t6_clean_s23", {s_mem[2], s_mem[3]}, {8'h03, 8'h02});

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
